// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, subtract divisor if it fits.
// Latency: combinational.
// Backpressure: none.
module div_restore_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] rem_shift;

    // The retained remainder is always below the divisor, so the result fits WIDTH bits
    // and the modular WIDTH-bit subtraction is exact.
    always_comb begin
        rem_shift = {rem, q_msb};
        q_bit     = (rem_shift >= {1'b0, den});
        rem_next  = q_bit ? (rem_shift[WIDTH-1:0] - den) : rem_shift[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_seq_ctrl.sv
// Unsigned WIDTH-bit divider, one quotient bit per clock, start/busy/done handshake.
// Latency: done WIDTH+2 cycles after accepted start (2 for divide-by-zero).
// Backpressure: start only accepted while idle; requests while busy are dropped.
module divider_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             error
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] den_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_step;
    logic             q_bit;
    logic             accept;
    logic             last_step;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .q_msb    (quo_q[WIDTH-1]),
        .den      (den_q),
        .rem_next (rem_step),
        .q_bit    (q_bit)
    );

    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            quo_q     <= '0;
            den_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            error     <= 1'b0;
        end else begin
            state_q <= state_d;
            // done trails the DONE state by one cycle, so it coincides with the return to idle.
            done    <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        quo_q <= dividend;
                        den_q <= divisor;
                        rem_q <= '0;
                        cnt_q <= '0;
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            error     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_step;
                    quo_q <= {quo_q[WIDTH-2:0], q_bit};
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        quotient  <= {quo_q[WIDTH-2:0], q_bit};
                        remainder <= rem_step;
                        error     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Self-checking bench for divider_seq_ctrl (WIDTH=4) against an arithmetic reference.
module tb_divider_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         error;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    divider_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .error     (error)
    );

    function automatic logic [W-1:0] ref_q(input int a, input int b);
        return (b == 0) ? W'((1 << W) - 1) : W'(a / b);
    endfunction

    function automatic logic [W-1:0] ref_r(input int a, input int b);
        return (b == 0) ? W'(a) : W'(a % b);
    endfunction

    function automatic int ref_lat(input int b);
        return (b == 0) ? 2 : W + 2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait (bounded) for done; lat = -1 on timeout.
    task automatic do_op(input int a, input int b, output logic [W-1:0] q,
                         output logic [W-1:0] r, output logic e, output int lat);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        step();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        q = quotient;
        r = remainder;
        e = error;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        dividend = W'($urandom_range(15, 0));
        divisor  = W'($urandom_range(15, 1));
        step();
        step();
        start = 1'b0;
        rst   = 1'b0;
        step();
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (quotient !== '0) begin bad++; $display("FAIL reset_quotient: got %0d want 0", quotient); end
        total++; if (remainder !== '0) begin bad++; $display("FAIL reset_remainder: got %0d want 0", remainder); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error); end
    endtask

    task automatic test_basic();
        int lat;
        dividend = 13;
        divisor  = 4;
        start    = 1'b1;
        step();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        total++; if (lat != 6) begin bad++; $display("FAIL basic_latency: got %0d want 6", lat); end
        total++; if (quotient !== 4'd3) begin bad++; $display("FAIL basic_quotient: got %0d want 3", quotient); end
        total++; if (remainder !== 4'd1) begin bad++; $display("FAIL basic_remainder: got %0d want 1", remainder); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL basic_error: got %b want 0", error); end
        step();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_single_pulse: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r;
        logic         e;
        int           lat;
        do_op(7, 0, q, r, e, lat);
        total++; if (lat != 2) begin bad++; $display("FAIL dz_latency: got %0d want 2", lat); end
        total++; if (q !== 4'd15 || r !== 4'd7 || e !== 1'b1) begin
            bad++; $display("FAIL dz_result: got q=%0d r=%0d e=%b want 15 7 1", q, r, e);
        end
        do_op(9, 3, q, r, e, lat);
        total++; if (q !== 4'd3 || r !== 4'd0 || e !== 1'b0 || lat != 6) begin
            bad++; $display("FAIL dz_clear: got q=%0d r=%0d e=%b lat=%0d want 3 0 0 6", q, r, e, lat);
        end
    endtask

    task automatic test_edges();
        int ea[4] = '{15, 3, 0, 15};
        int eb[4] = '{1, 7, 5, 15};
        logic [W-1:0] q, r;
        logic         e;
        int           lat;
        for (int i = 0; i < 4; i++) begin
            do_op(ea[i], eb[i], q, r, e, lat);
            total++;
            if (q !== ref_q(ea[i], eb[i]) || r !== ref_r(ea[i], eb[i]) || e !== 1'b0 || lat != ref_lat(eb[i])) begin
                bad++;
                $display("FAIL edge_%0d_%0d: got q=%0d r=%0d e=%b lat=%0d want q=%0d r=%0d e=0 lat=%0d",
                         ea[i], eb[i], q, r, e, lat, ref_q(ea[i], eb[i]), ref_r(ea[i], eb[i]), ref_lat(eb[i]));
            end
        end
    endtask

    task automatic test_hold_start();
        int last = -1;
        int n = 0;
        int wait_cyc;
        dividend = 10;
        divisor  = 3;
        start    = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            step();
            if (done === 1'b1) begin
                total++; if (quotient !== 4'd3 || remainder !== 4'd1) begin
                    bad++; $display("FAIL hold_result: got q=%0d r=%0d want 3 1", quotient, remainder);
                end
                if (last >= 0) begin
                    total++; if (cyc - last != W + 2) begin
                        bad++; $display("FAIL hold_period: got %0d want %0d", cyc - last, W + 2);
                    end
                end
                last = cyc;
                n++;
            end
        end
        total++; if (n != 6) begin bad++; $display("FAIL hold_count: got %0d want 6", n); end
        // Operand change in mid-RUN must not disturb the operation in flight.
        wait_cyc = 0;
        while (done !== 1'b1 && wait_cyc < 20) begin step(); wait_cyc++; end
        step();
        step();
        dividend = 1;
        divisor  = 1;
        wait_cyc = 0;
        step();
        while (done !== 1'b1 && wait_cyc < 20) begin step(); wait_cyc++; end
        total++; if (done !== 1'b1 || quotient !== 4'd3 || remainder !== 4'd1) begin
            bad++; $display("FAIL hold_midrun: got done=%b q=%0d r=%0d want 1 3 1", done, quotient, remainder);
        end
        wait_cyc = 0;
        step();
        while (done !== 1'b1 && wait_cyc < 20) begin step(); wait_cyc++; end
        start = 1'b0;
        total++; if (done !== 1'b1 || quotient !== 4'd1 || remainder !== 4'd0) begin
            bad++; $display("FAIL hold_next: got done=%b q=%0d r=%0d want 1 1 0", done, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r;
        logic         e;
        int           lat;
        int           spurious = 0;
        dividend = 14;
        divisor  = 3;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || error !== 1'b0) begin
            bad++; $display("FAIL rstmid_outputs: got busy=%b done=%b q=%0d r=%0d e=%b want all 0",
                            busy, done, quotient, remainder, error);
        end
        for (int i = 0; i < W + 4; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) spurious++;
        end
        total++; if (spurious != 0) begin bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", spurious); end
        do_op(14, 3, q, r, e, lat);
        total++; if (q !== 4'd4 || r !== 4'd2 || e !== 1'b0 || lat != 6) begin
            bad++; $display("FAIL rstmid_recover: got q=%0d r=%0d e=%b lat=%0d want 4 2 0 6", q, r, e, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q, r;
        logic         e;
        int           lat;
        int           a, b;
        for (int i = 0; i < 20; i++) begin
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            do_op(a, b, q, r, e, lat);
            total++;
            if (q !== ref_q(a, b) || r !== ref_r(a, b) || e !== (b == 0) || lat != ref_lat(b)) begin
                bad++;
                $display("FAIL b2b_%0d_%0d: got q=%0d r=%0d e=%b lat=%0d want q=%0d r=%0d e=%b lat=%0d",
                         a, b, q, r, e, lat, ref_q(a, b), ref_r(a, b), (b == 0), ref_lat(b));
            end
        end
    endtask

    task automatic test_sweep();
        logic [W-1:0] q, r;
        logic         e;
        int           lat, a, b, idx;
        int           mult = int'($urandom_range(127, 0)) * 2 + 1;
        int           off = int'($urandom_range(255, 0));
        for (int i = 0; i < 256; i++) begin
            idx = (i * mult + off) % 256;
            a   = idx / 16;
            b   = idx % 16;
            do_op(a, b, q, r, e, lat);
            total++;
            if (q !== ref_q(a, b) || r !== ref_r(a, b) || e !== (b == 0) || lat != ref_lat(b)) begin
                bad++;
                $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d e=%b lat=%0d want q=%0d r=%0d e=%b lat=%0d",
                         a, b, q, r, e, lat, ref_q(a, b), ref_r(a, b), (b == 0), ref_lat(b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_edges();
        test_hold_start();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
